// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the serial arithmetic family: FSM state encoding
//   and the default operand width. The planned serial subtractor reuses this
//   package.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_add.sv
// full_add
//   Combinational 1-bit full adder. This is the datapath cell of serial_adder.
//   Ports:
//     A, B  - operand bits
//     Cin   - carry in
//     sum   - A ^ B ^ Cin
//     Cout  - carry out (majority of A, B, Cin)
module full_add (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic sum,
    output logic Cout
);

    always_comb begin
        sum  = A ^ B ^ Cin;
        Cout = (A & B) | (A & Cin) | (B & Cin);
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. It captures a and b when it accepts a start in
//   IDLE. It then adds them LSB-first through a single full_add cell, one bit
//   per clock, over WIDTH clocks. After that it presents sum/cout together
//   with a one-cycle done pulse.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - synchronous active-low reset
//     start  - request, sampled only in IDLE
//     a, b   - WIDTH-bit unsigned operands, captured on the accepting edge
//     busy   - high while shifting
//     done   - one-cycle pulse, sum/cout valid
//     sum    - (a+b) mod 2^WIDTH, held until the next completion
//     cout   - carry out of bit WIDTH-1, held with sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cell_s;
    logic             cell_c;

    full_add u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .sum  (cell_s),
        .Cout (cell_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {cell_s, s_sr[WIDTH-1:1]};
                    carry <= cell_c;
                    count <= count + 1'b1;
                    // The final bit is taken straight from the cell, so the
                    // output register gets the complete sum on this edge.
                    if (count == LAST) begin
                        sum   <= {cell_s, s_sr[WIDTH-1:1]};
                        cout  <= cell_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    int n_vec = 0;
    int n_miss = 0;
    int n_done = 0;
    logic [W:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the expected {cout,sum} is pushed when the stimulus is driven
    // and popped here on each done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy === 1'b1 && done === 1'b1) chk("busy_and_done", 32'd1, 32'd0);
            if (done === 1'b1) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [W:0] e;
                    e = sb_q.pop_front();
                    chk("sb_sum", 32'(sum), 32'(e[W-1:0]));
                    chk("sb_cout", 32'(cout), 32'(e[W]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, then check latency and busy length.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int k;
        int nbusy;
        logic [W:0] e;
        e = {1'b0, ia} + {1'b0, ib};
        start = 1'b1;
        a = ia;
        b = ib;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        k = 0;
        nbusy = 0;
        while (done !== 1'b1 && k < 20) begin
            if (busy === 1'b1) nbusy++;
            tick();
            k++;
        end
        chk("done_latency", 32'(k), 32'd8);
        chk("busy_cycles", 32'(nbusy), 32'd8);
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vt[8];
        int t0;
        int dts[$];
        int cyc;

        vt[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vt[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vt[4] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vt[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vt[6] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vt[7] = '{8'hC8, 8'h64, 8'h2C, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table vectors, with the expected values listed in the table itself.
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b);
            chk("tbl_sum", 32'(sum), 32'(vt[i].s));
            chk("tbl_cout", 32'(cout), 32'(vt[i].c));
            tick();
        end

        // Outputs hold after 0xFF+0xFF with start low.
        run_op(8'hFF, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_sum", 32'(sum), 32'h0FE);
            chk("hold_cout", 32'(cout), 32'd1);
            chk("hold_done", 32'(done), 32'd0);
        end

        // A start pulse during shifting is ignored.
        n_done = 0;
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        sb_q.push_back(9'h030);
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("ign_sum", 32'(sum), 32'h030);
        chk("ign_cout", 32'(cout), 32'd0);
        chk("ign_done_count", 32'(n_done), 32'd1);

        // A reset in the middle of shifting abandons the operation.
        n_done = 0;
        start = 1'b1;
        a = 8'h80;
        b = 8'h80;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("mid_rst_no_done", 32'(n_done), 32'd0);
        run_op(8'h01, 8'h02);
        chk("after_rst_sum", 32'(sum), 32'h003);
        tick();

        // Start held high: back-to-back accepts every WIDTH+2 cycles.
        for (int i = 0; i < 3; i++) sb_q.push_back(9'h002);
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        tick();
        t0 = 0;
        cyc = 0;
        while (dts.size() < 3 && cyc < 60) begin
            if (done === 1'b1) begin
                dts.push_back(cyc);
                if (dts.size() == 3) start = 1'b0;
            end
            if (dts.size() < 3) begin
                tick();
                cyc++;
            end
        end
        chk("b2b_pulses", 32'(dts.size()), 32'd3);
        for (int i = 0; i < dts.size(); i++)
            chk("b2b_done_edge", 32'(dts[i] - t0), 32'(8 + 10 * i));
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
